// File: rtl/cpu_sequencer_pkg.sv
// rtl/cpu_sequencer_pkg.sv - shared state encoding and constants for the cpu sequencer
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  typedef struct packed {
    logic branch;
    logic ubranch;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } flags_t;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/cpu_mem_wait_timer.sv
// rtl/cpu_mem_wait_timer.sv - wait-cycle counter with timeout compare, shared by fetch and memory
module cpu_mem_wait_timer #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT - 1);

  logic [7:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 8'd1;
    end
  end

  // Fires on the cycle that would be the MAX_WAIT-th without ready.
  assign expire = tick && (count == LIMIT);

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/execute/memory/writeback sequencer
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned     XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     MAX_WAIT  = 16,
  parameter logic [31:0]     HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instruction,
  input  logic            branch_flag,
  input  logic            ubranch_flag,
  input  logic            mem_read_flag,
  input  logic            mem_write_flag,
  input  logic            reg_write_flag,
  input  logic            mem_to_reg_flag,
  input  logic [XLEN-1:0] pc_offset,
  input  logic [XLEN-1:0] alu_result,
  input  logic            zero_flag,
  input  logic [XLEN-1:0] store_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_we,
  output logic [XLEN-1:0] rf_wdata,
  output logic [XLEN-1:0] pc,
  output logic [2:0]      state,
  output logic            halted,
  output logic            fault,
  output logic [31:0]     retired
);

  state_t          state_q, next_state;
  flags_t          flags_q;
  logic [XLEN-1:0] pc_q, alu_q, st_q, mdr_q;
  logic [31:0]     ir_q, retired_q;
  logic            z_q, z_now, taken, complete;
  logic            in_wait, ready_in, expire;

  assign in_wait  = (state_q == S_FETCH) || (state_q == S_MEMORY);
  assign ready_in = (state_q == S_FETCH)  ? imem_ready :
                    (state_q == S_MEMORY) ? dmem_ready : 1'b0;

  cpu_mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (next_state != state_q),
    .tick   (in_wait && !ready_in),
    .expire (expire)
  );

  // A branch completes in EXECUTE, before zero_flag has landed in z_q.
  assign z_now = (state_q == S_EXECUTE) ? zero_flag : z_q;
  assign taken = flags_q.ubranch | (flags_q.branch & z_now);

  always_comb begin
    next_state = state_q;
    complete   = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready)  next_state = S_DECODE;
        else if (expire) next_state = S_FAULT;
      end
      S_DECODE: next_state = (ir_q == HALT_WORD) ? S_HALT : S_EXECUTE;
      S_EXECUTE: begin
        if (flags_q.mem_read || flags_q.mem_write) next_state = S_MEMORY;
        else if (flags_q.reg_write)                next_state = S_WRITEBACK;
        else                                       complete   = 1'b1;
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = flags_q.mem_write;
        if (dmem_ready) begin
          if (flags_q.reg_write) next_state = S_WRITEBACK;
          else                   complete   = 1'b1;
        end else if (expire) begin
          next_state = S_FAULT;
        end
      end
      S_WRITEBACK: begin
        rf_we    = 1'b1;
        complete = 1'b1;
      end
      default: ;
    endcase
    if (complete) next_state = S_FETCH;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      flags_q   <= '0;
      alu_q     <= '0;
      z_q       <= 1'b0;
      st_q      <= '0;
      mdr_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q <= next_state;
      case (state_q)
        S_FETCH:   if (imem_ready) ir_q <= imem_rdata;
        S_DECODE:  if (ir_q != HALT_WORD)
                     flags_q <= {branch_flag, ubranch_flag, mem_read_flag,
                                 mem_write_flag, reg_write_flag, mem_to_reg_flag};
        S_EXECUTE: begin
          alu_q <= alu_result;
          z_q   <= zero_flag;
          st_q  <= store_data;
        end
        // A combined read+write is treated as a write, so mdr keeps its value.
        S_MEMORY:  if (dmem_ready && flags_q.mem_read && !flags_q.mem_write) mdr_q <= dmem_rdata;
        default: ;
      endcase
      if (complete) begin
        pc_q      <= taken ? pc_q + (pc_offset << 2) : pc_q + XLEN'(PC_INC);
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  assign imem_addr   = pc_q;
  assign instruction = ir_q;
  assign dmem_addr   = alu_q;
  assign dmem_wdata  = st_q;
  assign rf_wdata    = flags_q.mem_to_reg ? mdr_q : alu_q;
  assign pc          = pc_q;
  assign state       = state_q;
  assign halted      = (state_q == S_HALT);
  assign fault       = (state_q == S_FAULT);
  assign retired     = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_ready = 1'b0;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata = '0, instruction;
  logic        branch_flag = 0, ubranch_flag = 0, mem_read_flag = 0;
  logic        mem_write_flag = 0, reg_write_flag = 0, mem_to_reg_flag = 0;
  logic [63:0] pc_offset = '0, alu_result = '0, store_data = '0, dmem_rdata = '0;
  logic        zero_flag = 1'b0, dmem_ready = 1'b0;
  logic        dmem_req, dmem_we, rf_we, halted, fault;
  logic [63:0] dmem_addr, dmem_wdata, rf_wdata, pc;
  logic [2:0]  state;
  logic [31:0] retired;

  int checks = 0;
  int failures = 0;

  localparam logic [5:0] FL_NOP = 6'b000000, FL_ALU = 6'b000010, FL_LOAD = 6'b001011,
                         FL_STORE = 6'b000100, FL_CBZ = 6'b100000, FL_B = 6'b010000,
                         FL_RW = 6'b001111;

  cpu_sequencer dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instruction(instruction),
    .branch_flag(branch_flag), .ubranch_flag(ubranch_flag), .mem_read_flag(mem_read_flag),
    .mem_write_flag(mem_write_flag), .reg_write_flag(reg_write_flag), .mem_to_reg_flag(mem_to_reg_flag),
    .pc_offset(pc_offset), .alu_result(alu_result), .zero_flag(zero_flag), .store_data(store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_wdata(rf_wdata), .pc(pc), .state(state),
    .halted(halted), .fault(fault), .retired(retired)
  );

  always #5 clock = ~clock;

  // Leaves the bench at a negedge with the DUT in its first FETCH cycle.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Acts as zero/fixed-wait instruction and data memories for one instruction.
  task automatic run_instr(input logic [31:0] word, input logic [5:0] fl, input logic [63:0] alu,
                           input logic zf, input logic [63:0] sd, input logic [63:0] off,
                           input logic [63:0] rdata, input int iw, input int dw,
                           output int cyc, output int rf_n, output int rf_at,
                           output logic [63:0] rf_v, output int dm_bad, output bit tmo);
    int ic, dc;
    bit left;
    ic = 0; dc = 0; left = 0; cyc = 0; rf_n = 0; rf_at = 0; rf_v = '0; dm_bad = 0; tmo = 1;
    imem_rdata = word;
    {branch_flag, ubranch_flag, mem_read_flag, mem_write_flag, reg_write_flag, mem_to_reg_flag} = fl;
    alu_result = alu; zero_flag = zf; store_data = sd; pc_offset = off; dmem_rdata = rdata;
    for (int n = 0; n < 300; n++) begin
      if (halted || fault || (imem_req && left)) begin tmo = 0; break; end
      if (!imem_req) left = 1;
      if (rf_we) begin rf_n++; rf_v = rf_wdata; rf_at = cyc + 1; end
      if (dmem_req && (dmem_addr !== alu || dmem_we !== fl[2] || dmem_wdata !== sd)) dm_bad++;
      imem_ready = imem_req && (ic == iw);
      if (imem_req) ic++;
      dmem_ready = dmem_req && (dc == dw);
      if (dmem_req) dc++;
      cyc++;
      @(negedge clock);
    end
    imem_ready = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (state !== S_FETCH || pc !== 64'd0 || retired !== 32'd0 || instruction !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: state=%0d pc=%h retired=%0d ir=%h, want 0/0/0/0", state, pc, retired, instruction);
    end
    checks++;
    if (imem_req !== 1'b1 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || rf_we !== 1'b0 ||
        halted !== 1'b0 || fault !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: imem_req=%b dmem_req=%b dmem_we=%b rf_we=%b halted=%b fault=%b, want 1,0,0,0,0,0",
               imem_req, dmem_req, dmem_we, rf_we, halted, fault);
    end
    checks++;
    if (rf_wdata !== 64'd0 || dmem_addr !== 64'd0 || dmem_wdata !== 64'd0) begin
      failures++;
      $display("FAIL reset_data: rf_wdata=%h dmem_addr=%h dmem_wdata=%h, want 0", rf_wdata, dmem_addr, dmem_wdata);
    end
  endtask

  task automatic test_alu_and_load();
    int cyc, rf_n, rf_at, dm_bad; logic [63:0] rf_v; bit tmo;
    do_reset();
    run_instr(32'h8B02_0020, FL_ALU, 64'd5, 1'b0, 64'd0, 64'd0, 64'd0, 0, 0, cyc, rf_n, rf_at, rf_v, dm_bad, tmo);
    checks++;
    if (tmo || cyc != 4 || rf_n != 1 || rf_at != 4 || rf_v !== 64'd5) begin
      failures++;
      $display("FAIL alu_op: tmo=%0b cyc=%0d rf_n=%0d rf_at=%0d rf_v=%0d, want 0/4/1/4/5", tmo, cyc, rf_n, rf_at, rf_v);
    end
    checks++;
    if (pc !== 64'd4 || retired !== 32'd1) begin
      failures++;
      $display("FAIL alu_pc: pc=%h retired=%0d, want 4/1", pc, retired);
    end
    run_instr(32'hF840_0000, FL_LOAD, 64'h100, 1'b0, 64'd0, 64'd0, 64'hABCD, 0, 3, cyc, rf_n, rf_at, rf_v, dm_bad, tmo);
    checks++;
    if (tmo || cyc != 8 || rf_n != 1 || rf_at != 8 || rf_v !== 64'hABCD || dm_bad != 0) begin
      failures++;
      $display("FAIL load_wait: tmo=%0b cyc=%0d rf_n=%0d rf_at=%0d rf_v=%h dm_bad=%0d, want 0/8/1/8/abcd/0",
               tmo, cyc, rf_n, rf_at, rf_v, dm_bad);
    end
  endtask

  task automatic test_cbz();
    int cyc, rf_n, rf_at, dm_bad; logic [63:0] rf_v; bit tmo;
    for (int z = 1; z >= 0; z--) begin
      do_reset();
      for (int i = 0; i < 4; i++)
        run_instr(32'h0000_0011, FL_NOP, 64'd0, 1'b0, 64'd0, 64'd0, 64'd0, 0, 0, cyc, rf_n, rf_at, rf_v, dm_bad, tmo);
      run_instr(32'hB400_0000, FL_CBZ, 64'd0, z[0], 64'd0, -64'sd2, 64'd0, 0, 0, cyc, rf_n, rf_at, rf_v, dm_bad, tmo);
      checks++;
      if (tmo || cyc != 3 || rf_n != 0 || pc !== ((z == 1) ? 64'h08 : 64'h14)) begin
        failures++;
        $display("FAIL cbz_z%0d: tmo=%0b cyc=%0d rf_n=%0d pc=%h, want 0/3/0/%h", z, tmo, cyc, rf_n, pc,
                 (z == 1) ? 64'h08 : 64'h14);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    imem_rdata = 32'h0000_0011;
    repeat (15) @(negedge clock);
    checks++;
    if (fault !== 1'b0 || state !== S_FETCH) begin
      failures++;
      $display("FAIL timeout_early: fault=%b state=%0d, want 0/%0d", fault, state, S_FETCH);
    end
    @(negedge clock);
    checks++;
    if (fault !== 1'b1 || state !== S_FAULT) begin
      failures++;
      $display("FAIL timeout_fault: fault=%b state=%0d, want 1/%0d", fault, state, S_FAULT);
    end
    imem_ready = 1'b1;
    repeat (3) @(negedge clock);
    imem_ready = 1'b0;
    checks++;
    if (fault !== 1'b1 || imem_req !== 1'b0 || pc !== 64'd0) begin
      failures++;
      $display("FAIL fault_sticky: fault=%b imem_req=%b pc=%h, want 1/0/0", fault, imem_req, pc);
    end
    do_reset();
    repeat (15) @(negedge clock);
    imem_ready = 1'b1;
    @(negedge clock);
    imem_ready = 1'b0;
    checks++;
    if (fault !== 1'b0 || state !== S_DECODE) begin
      failures++;
      $display("FAIL ready_wins: fault=%b state=%0d, want 0/%0d", fault, state, S_DECODE);
    end
  endtask

  task automatic test_halt();
    int cyc, rf_n, rf_at, dm_bad, bad; logic [63:0] rf_v; bit tmo;
    do_reset();
    run_instr(32'h8B02_0020, FL_ALU, 64'd9, 1'b0, 64'd0, 64'd0, 64'd0, 0, 0, cyc, rf_n, rf_at, rf_v, dm_bad, tmo);
    run_instr(HALT_WORD_DEFAULT, FL_B, 64'd0, 1'b0, 64'd0, 64'd100, 64'd0, 0, 0, cyc, rf_n, rf_at, rf_v, dm_bad, tmo);
    checks++;
    if (tmo || cyc != 2 || halted !== 1'b1 || state !== S_HALT) begin
      failures++;
      $display("FAIL halt_enter: tmo=%0b cyc=%0d halted=%b state=%0d, want 0/2/1/%0d", tmo, cyc, halted, state, S_HALT);
    end
    bad = 0;
    imem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (imem_req !== 1'b0 || pc !== 64'd4 || halted !== 1'b1 || retired !== 32'd1) bad++;
    end
    imem_ready = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL halt_sticky: bad_cycles=%0d pc=%h retired=%0d, want 0 bad, pc 4, retired 1", bad, pc, retired);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, rf_n, rf_at, dm_bad; logic [63:0] rf_v; bit tmo;
    do_reset();
    run_instr(32'h8B02_0020, FL_ALU, 64'd7, 1'b0, 64'd0, 64'd0, 64'd0, 0, 0, cyc, rf_n, rf_at, rf_v, dm_bad, tmo);
    {branch_flag, ubranch_flag, mem_read_flag, mem_write_flag, reg_write_flag, mem_to_reg_flag} = FL_LOAD;
    imem_rdata = 32'hF840_0000; alu_result = 64'h200;
    imem_ready = 1'b1;
    @(negedge clock);
    imem_ready = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (dmem_req !== 1'b1 || dmem_addr !== 64'h200) begin
      failures++;
      $display("FAIL mid_precond: dmem_req=%b dmem_addr=%h, want 1/200", dmem_req, dmem_addr);
    end
    reset = 1'b1; dmem_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (dmem_req !== 1'b0 || pc !== 64'd0 || state !== S_FETCH || imem_req !== 1'b1 || retired !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid: dmem_req=%b pc=%h state=%0d imem_req=%b retired=%0d, want 0/0/0/1/0",
               dmem_req, pc, state, imem_req, retired);
    end
    reset = 1'b0; dmem_ready = 1'b0;
  endtask

  // Random instruction stream against a cycle-count / architectural-state model.
  task automatic test_back_to_back();
    int cyc, rf_n, rf_at, dm_bad, iw, dw, kind, exp_cyc;
    logic [63:0] rf_v, alu, sd, rdata, off, pc_m, mdr_m, exp_rf;
    logic [31:0] ret_m;
    logic [5:0] fl;
    logic zf;
    bit tmo, taken;
    do_reset();
    pc_m = '0; mdr_m = '0; ret_m = '0;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0: fl = FL_ALU;   1: fl = FL_LOAD; 2: fl = FL_STORE; 3: fl = FL_CBZ;
        4: fl = FL_B;     5: fl = FL_NOP;  default: fl = FL_RW;
      endcase
      alu = {$urandom, $urandom}; sd = {$urandom, $urandom}; rdata = {$urandom, $urandom};
      off = 64'($signed($urandom_range(0, 64)) - 32);
      zf = 1'($urandom_range(0, 1));
      iw = $urandom_range(0, 5); dw = $urandom_range(0, 5);
      exp_cyc = iw + 3 + ((fl[3] | fl[2]) ? dw + 1 : 0) + (fl[1] ? 1 : 0);
      if (fl[3] && !fl[2]) mdr_m = rdata;
      exp_rf = fl[0] ? mdr_m : alu;
      taken = fl[4] | (fl[5] & zf);
      pc_m = taken ? pc_m + off * 64'd4 : pc_m + 64'd4;
      ret_m = ret_m + 32'd1;
      run_instr($urandom & 32'h7FFF_FFFF, fl, alu, zf, sd, off, rdata, iw, dw,
                cyc, rf_n, rf_at, rf_v, dm_bad, tmo);
      checks++;
      if (tmo || cyc != exp_cyc || dm_bad != 0) begin
        failures++;
        $display("FAIL rand_timing[%0d]: kind=%0d tmo=%0b cyc=%0d dm_bad=%0d, want 0/%0d/0", i, kind, tmo, cyc, dm_bad, exp_cyc);
      end
      checks++;
      if (rf_n != int'(fl[1]) || (fl[1] && rf_v !== exp_rf)) begin
        failures++;
        $display("FAIL rand_rf[%0d]: kind=%0d rf_n=%0d rf_v=%h, want %0d/%h", i, kind, rf_n, rf_v, fl[1], exp_rf);
      end
      checks++;
      if (pc !== pc_m || retired !== ret_m) begin
        failures++;
        $display("FAIL rand_pc[%0d]: kind=%0d pc=%h retired=%0d, want %h/%0d", i, kind, pc, retired, pc_m, ret_m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_and_load();
    test_cbz();
    test_timeout();
    test_halt();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter XLEN, default 64: datapath, PC and data-memory width.
REQ-002 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 Parameter MAX_WAIT, default 16: max memory-wait cycles before fault; range 1..255.
REQ-004 Parameter HALT_WORD, default 32'hFFFF_FFFF: instruction encoding that halts the core.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 Ports: clock in 1 system clock; reset in 1 sync active-high reset.
REQ-007 imem_req out 1 fetch request; imem_addr out XLEN fetch address; imem_ready in 1 fetch done; imem_rdata in 32 fetched word.
REQ-008 instruction out 32 held IR, the controller's input; branch_flag, ubranch_flag, mem_read_flag, mem_write_flag, reg_write_flag, mem_to_reg_flag in 1 each, decoded from instruction.
REQ-009 pc_offset in XLEN sign-extended word offset; alu_result in XLEN; zero_flag in 1; store_data in XLEN register read data 2.
REQ-010 dmem_req out 1; dmem_we out 1; dmem_addr out XLEN; dmem_wdata out XLEN; dmem_ready in 1; dmem_rdata in XLEN.
REQ-011 rf_we out 1 register-file write enable; rf_wdata out XLEN; pc out XLEN; state out 3; halted out 1; fault out 1; retired out 32.

Function
REQ-012 States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT, FAULT; state output shows current encoding.
REQ-013 FETCH: imem_req=1, imem_addr=pc; on imem_ready, IR<=imem_rdata, go to DECODE.
REQ-014 DECODE: one cycle; IR==HALT_WORD -> HALT; else latch all six decode flags, go to EXECUTE.
REQ-015 EXECUTE: one cycle; latch alu_result->alu_q, zero_flag->z_q, store_data->st_q; next MEMORY if mem_read or mem_write latched, else WRITEBACK if reg_write, else complete.
REQ-016 MEMORY: dmem_req=1, dmem_addr=alu_q, dmem_wdata=st_q, dmem_we=mem_write; outputs held stable until dmem_ready.
REQ-017 On dmem_ready in MEMORY: if mem_read, mdr<=dmem_rdata; then WRITEBACK if reg_write, else complete.
REQ-018 Both mem_read and mem_write latched: access is a write; mdr not updated.
REQ-019 WRITEBACK: rf_we=1 for exactly one cycle; rf_wdata = mem_to_reg ? mdr : alu_q; then complete.
REQ-020 Complete: taken = ubranch | (branch & z_q); pc <= taken ? pc + (pc_offset<<2) : pc + 4, modulo 2^XLEN; retired += 1 (wraps at 2^32); next FETCH.
REQ-021 Minimum latencies with zero-wait memory: branch/no-write 3 cycles, ALU op 4, store 4, load 5.
REQ-022 Wait counter clears on entering FETCH or MEMORY and counts each cycle without ready; reaching MAX_WAIT -> FAULT.
REQ-023 Ready in the same cycle the counter reaches MAX_WAIT: ready wins, no fault.
REQ-024 HALT: halted=1, pc frozen; sticky until reset. FAULT: fault=1, pc frozen; sticky until reset.
REQ-025 imem_req, dmem_req and rf_we are 0 outside their stated states.
REQ-026 Ready inputs outside the matching request state are ignored.

Reset
REQ-027 Reset dominates all other inputs: state=FETCH, pc=RESET_PC, IR=0, alu_q=mdr=st_q=0, flags=0, retired=0, halted=0, fault=0, wait counter=0.
REQ-028 Reset mid-handshake: request drops the cycle after reset is sampled; the in-flight transfer is discarded.
REQ-029 Reset outputs: imem_req=1 after reset release (FETCH); dmem_req=dmem_we=rf_we=0; rf_wdata=dmem_addr=dmem_wdata=0.

Structure
REQ-030 Shared package holds the state enumeration, the opcode-independent HALT_WORD default and the PC increment constant 4.
REQ-031 Single sub-module cpu_mem_wait_timer (wait counter plus timeout compare), instantiated once and shared by FETCH and MEMORY.

Verification
REQ-032 ALU op, IR=ADD, alu_result=5, zero-wait memory -> rf_we=1 in 4th cycle, rf_wdata=5, pc 0->4, retired=1.
REQ-033 Load, alu_result=0x100, dmem_ready after 3 wait cycles, dmem_rdata=0xABCD -> dmem_addr=0x100 held, rf_wdata=0xABCD, 8 cycles total.
REQ-034 CBZ, zero_flag=1, pc_offset=-2, pc=0x10 -> pc=0x08; same case with zero_flag=0 -> pc=0x14.
REQ-035 imem_ready withheld 16 cycles -> fault=1, state=FAULT; ready on 16th cycle instead -> no fault.
REQ-036 IR=HALT_WORD -> halted=1, pc unchanged, no further imem_req; reset asserted during MEMORY wait -> dmem_req=0 the next cycle, pc=RESET_PC.
